map_table_ckpt: RTL and testbench

Parametrised rename map table for the out-of-order core, sitting between dispatch and the RS/ROB. It maps architectural registers to ROB tags and tracks operand readiness for DISPATCH_W instructions per cycle. It also tracks readiness from CDB_W broadcast buses and clears entries on ROB retire. It holds up to NUM_CKPT branch checkpoints so a mispredict restores the whole table in one cycle.

---
 rtl/map_table_ckpt_if.sv | 54 +++++
 rtl/map_table_ckpt.sv | 176 +++++++++++++++++
 tb/tb_map_table_ckpt.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_table_ckpt_if.sv
// Signal bundle between the rename/dispatch driver and the checkpointed map table.
// master drives dispatch, completion, retire and checkpoint control; slave answers lookups.
interface map_table_ckpt_if #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int TAG_W         = 5,
    parameter int DISPATCH_W    = 2,
    parameter int CDB_W         = 2,
    parameter int NUM_CKPT      = 4
) ();
    localparam int IDX_W  = $clog2(NUM_ARCH_REGS);
    localparam int SLOT_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;
    localparam int CKPT_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    logic                        stall;
    logic [DISPATCH_W-1:0]       disp_valid;
    logic [DISPATCH_W*IDX_W-1:0] disp_dest_idx;
    logic [DISPATCH_W*TAG_W-1:0] disp_tag;
    logic [DISPATCH_W*IDX_W-1:0] src1_idx;
    logic [DISPATCH_W*IDX_W-1:0] src2_idx;
    logic [DISPATCH_W-1:0]       src1_tag_valid;
    logic [DISPATCH_W-1:0]       src2_tag_valid;
    logic [DISPATCH_W*TAG_W-1:0] src1_tag;
    logic [DISPATCH_W*TAG_W-1:0] src2_tag;
    logic [DISPATCH_W-1:0]       src1_ready;
    logic [DISPATCH_W-1:0]       src2_ready;
    logic [CDB_W-1:0]            cdb_valid;
    logic [CDB_W*TAG_W-1:0]      cdb_tag;
    logic                        retire_valid;
    logic [TAG_W-1:0]            retire_tag;
    logic                        ckpt_req;
    logic [SLOT_W-1:0]           ckpt_slot;
    logic [CKPT_W-1:0]           ckpt_id;
    logic                        ckpt_full;
    logic                        ckpt_empty;
    logic                        ckpt_commit;
    logic                        recover_valid;
    logic [CKPT_W-1:0]           recover_id;

    modport master (
        output stall, disp_valid, disp_dest_idx, disp_tag, src1_idx, src2_idx,
        output cdb_valid, cdb_tag, retire_valid, retire_tag,
        output ckpt_req, ckpt_slot, ckpt_commit, recover_valid, recover_id,
        input  src1_tag_valid, src2_tag_valid, src1_tag, src2_tag, src1_ready, src2_ready,
        input  ckpt_id, ckpt_full, ckpt_empty
    );

    modport slave (
        input  stall, disp_valid, disp_dest_idx, disp_tag, src1_idx, src2_idx,
        input  cdb_valid, cdb_tag, retire_valid, retire_tag,
        input  ckpt_req, ckpt_slot, ckpt_commit, recover_valid, recover_id,
        output src1_tag_valid, src2_tag_valid, src1_tag, src2_tag, src1_ready, src2_ready,
        output ckpt_id, ckpt_full, ckpt_empty
    );
endinterface

// File: rtl/map_table_ckpt.sv
// Rename map table (arch reg -> ROB tag + ready) with a circular buffer of
// branch checkpoints that restore the whole table in a single cycle.
module map_table_ckpt #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int TAG_W         = 5,
    parameter int DISPATCH_W    = 2,
    parameter int CDB_W         = 2,
    parameter int NUM_CKPT      = 4
) (
    input  logic            clock,
    input  logic            reset,
    map_table_ckpt_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_ARCH_REGS);
    localparam int SLOT_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;
    localparam int CKPT_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    typedef struct packed {
        logic             tv;
        logic [TAG_W-1:0] tag;
        logic             rdy;
    } entry_t;

    entry_t            r_table [NUM_ARCH_REGS];
    entry_t            r_snap  [NUM_CKPT][NUM_ARCH_REGS];
    logic [CKPT_W-1:0] r_head;
    logic [CKPT_W-1:0] r_tail;
    logic [CKPT_W:0]   r_count;

    entry_t            w_aged      [NUM_ARCH_REGS];
    entry_t            w_snap_aged [NUM_CKPT][NUM_ARCH_REGS];
    entry_t            w_image     [NUM_ARCH_REGS];
    entry_t            w_next      [NUM_ARCH_REGS];
    logic [IDX_W-1:0]  w_dest      [DISPATCH_W];
    logic [TAG_W-1:0]  w_dtag      [DISPATCH_W];
    logic [DISPATCH_W-1:0] w_write;
    logic [IDX_W-1:0]  w_sidx      [2][DISPATCH_W];
    entry_t            w_sres      [2][DISPATCH_W];
    logic              w_full;
    logic              w_empty;
    logic              w_commit;
    logic              w_take;
    logic [CKPT_W-1:0] w_head_n;

    function automatic logic cdb_match(input logic [TAG_W-1:0]       t,
                                       input logic [CDB_W-1:0]       v,
                                       input logic [CDB_W*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++)
            if (v[c] && tags[c*TAG_W +: TAG_W] == t) hit = 1'b1;
        return hit;
    endfunction

    // Retire clear outranks the CDB ready-set on the same entry.
    function automatic entry_t age_entry(input entry_t e, input logic hit,
                                         input logic ret_v, input logic [TAG_W-1:0] ret_tag);
        entry_t n;
        n = e;
        if (e.tv && ret_v && e.tag == ret_tag)
            n = '0;
        else if (e.tv && hit)
            n.rdy = 1'b1;
        return n;
    endfunction

    always_comb begin
        for (int r = 0; r < NUM_ARCH_REGS; r++)
            w_aged[r] = age_entry(r_table[r], cdb_match(r_table[r].tag, bus.cdb_valid, bus.cdb_tag),
                                  bus.retire_valid, bus.retire_tag);
        for (int c = 0; c < NUM_CKPT; c++)
            for (int r = 0; r < NUM_ARCH_REGS; r++)
                w_snap_aged[c][r] = age_entry(r_snap[c][r],
                                              cdb_match(r_snap[c][r].tag, bus.cdb_valid, bus.cdb_tag),
                                              bus.retire_valid, bus.retire_tag);
    end

    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            w_dest[k]    = bus.disp_dest_idx[k*IDX_W +: IDX_W];
            w_dtag[k]    = bus.disp_tag[k*TAG_W +: TAG_W];
            w_write[k]   = bus.disp_valid[k] && (w_dest[k] != '0);
            w_sidx[0][k] = bus.src1_idx[k*IDX_W +: IDX_W];
            w_sidx[1][k] = bus.src2_idx[k*IDX_W +: IDX_W];
        end
    end

    assign w_full   = (r_count == (CKPT_W+1)'(NUM_CKPT));
    assign w_empty  = (r_count == '0);
    assign w_commit = bus.ckpt_commit && !w_empty;
    assign w_take   = bus.ckpt_req && !bus.stall && !w_full && !bus.recover_valid;
    assign w_head_n = r_head + CKPT_W'(w_commit);

    // Ascending slot order lets the youngest writer of a register win.
    always_comb begin
        w_image = w_aged;
        w_next  = w_aged;
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (w_write[k]) begin
                if (!bus.stall)
                    w_next[w_dest[k]] = {1'b1, w_dtag[k], 1'b0};
                if (SLOT_W'(k) <= bus.ckpt_slot)
                    w_image[w_dest[k]] = {1'b1, w_dtag[k], 1'b0};
            end
        end
        if (bus.recover_valid)
            w_next = w_snap_aged[bus.recover_id];
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                w_sres[s][k] = '0;
                if (w_sidx[s][k] != '0 && r_table[w_sidx[s][k]].tv) begin
                    w_sres[s][k]     = r_table[w_sidx[s][k]];
                    w_sres[s][k].rdy = r_table[w_sidx[s][k]].rdy |
                                       cdb_match(r_table[w_sidx[s][k]].tag, bus.cdb_valid, bus.cdb_tag);
                end
                for (int j = 0; j < DISPATCH_W; j++)
                    if (j < k && w_write[j] && w_dest[j] == w_sidx[s][k])
                        w_sres[s][k] = {1'b1, w_dtag[j], 1'b0};
            end
        end
    end

    always_comb begin
        bus.src1_tag_valid = '0;
        bus.src2_tag_valid = '0;
        bus.src1_tag       = '0;
        bus.src2_tag       = '0;
        bus.src1_ready     = '0;
        bus.src2_ready     = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            bus.src1_tag_valid[k]           = w_sres[0][k].tv;
            bus.src1_tag[k*TAG_W +: TAG_W]  = w_sres[0][k].tag;
            bus.src1_ready[k]               = w_sres[0][k].rdy;
            bus.src2_tag_valid[k]           = w_sres[1][k].tv;
            bus.src2_tag[k*TAG_W +: TAG_W]  = w_sres[1][k].tag;
            bus.src2_ready[k]               = w_sres[1][k].rdy;
        end
    end

    assign bus.ckpt_id    = r_tail;
    assign bus.ckpt_full  = w_full;
    assign bus.ckpt_empty = w_empty;

    // Recovery frees the restored checkpoint and everything allocated after it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++)
                r_table[r] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_table <= w_next;
            r_head  <= w_head_n;
            if (bus.recover_valid) begin
                r_tail  <= bus.recover_id;
                r_count <= {1'b0, bus.recover_id - w_head_n};
            end else begin
                r_tail  <= r_tail + CKPT_W'(w_take);
                r_count <= r_count + (CKPT_W+1)'(w_take) - (CKPT_W+1)'(w_commit);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CKPT; c++)
            for (int r = 0; r < NUM_ARCH_REGS; r++)
                if (w_take && r_tail == CKPT_W'(c))
                    r_snap[c][r] <= w_image[r];
                else
                    r_snap[c][r] <= w_snap_aged[c][r];
    end
endmodule

// File: tb/tb_map_table_ckpt.sv
// Bench for map_table_ckpt: directed scenarios followed by random traffic,
// all outputs compared every cycle against an array-based model of the rename rules.
module tb_map_table_ckpt;
    localparam int NREG = 32;
    localparam int TW   = 5;
    localparam int DW   = 2;
    localparam int CW   = 2;
    localparam int NCK  = 4;
    localparam int IW   = 5;
    localparam int LIVE = NCK;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    map_table_ckpt_if #(.NUM_ARCH_REGS(NREG), .TAG_W(TW), .DISPATCH_W(DW), .CDB_W(CW),
                        .NUM_CKPT(NCK)) bus ();
    map_table_ckpt #(.NUM_ARCH_REGS(NREG), .TAG_W(TW), .DISPATCH_W(DW), .CDB_W(CW),
                     .NUM_CKPT(NCK)) dut (.clock(clock), .reset(reset), .bus(bus));

    int nChecks = 0;
    int nFail   = 0;

    logic          sStall;
    logic [DW-1:0] sDv;
    int            sDest [DW];
    int            sTag  [DW];
    int            sSrc1 [DW];
    int            sSrc2 [DW];
    logic [CW-1:0] sCv;
    int            sCtag [CW];
    logic          sRv;
    int            sRtag;
    logic          sReq;
    int            sSlot;
    logic          sCommit;
    logic          sRec;
    int            sRid;

    // Images 0..NCK-1 are checkpoints, image LIVE is the architectural table.
    int mTv  [NCK+1][NREG];
    int mTag [NCK+1][NREG];
    int mRdy [NCK+1][NREG];
    int mHead, mTail, mCount;

    task automatic checkOutput(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit cdbHit(input int t);
        for (int c = 0; c < CW; c++)
            if (sCv[c] && sCtag[c] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clearStim();
        sStall = 0; sDv = '0; sCv = '0; sRv = 0; sRtag = 0;
        sReq = 0; sSlot = 0; sCommit = 0; sRec = 0; sRid = 0;
        for (int k = 0; k < DW; k++) begin
            sDest[k] = 0; sTag[k] = 0; sSrc1[k] = 0; sSrc2[k] = 0;
        end
        for (int c = 0; c < CW; c++) sCtag[c] = 0;
    endtask

    task automatic driveInputs();
        bus.stall         = sStall;
        bus.disp_valid    = sDv;
        bus.cdb_valid     = sCv;
        bus.retire_valid  = sRv;
        bus.retire_tag    = TW'(sRtag);
        bus.ckpt_req      = sReq;
        bus.ckpt_slot     = 1'(sSlot);
        bus.ckpt_commit   = sCommit;
        bus.recover_valid = sRec;
        bus.recover_id    = 2'(sRid);
        for (int k = 0; k < DW; k++) begin
            bus.disp_dest_idx[k*IW +: IW] = IW'(sDest[k]);
            bus.disp_tag[k*TW +: TW]      = TW'(sTag[k]);
            bus.src1_idx[k*IW +: IW]      = IW'(sSrc1[k]);
            bus.src2_idx[k*IW +: IW]      = IW'(sSrc2[k]);
        end
        for (int c = 0; c < CW; c++) bus.cdb_tag[c*TW +: TW] = TW'(sCtag[c]);
    endtask

    task automatic modelReset();
        for (int i = 0; i <= NCK; i++)
            for (int r = 0; r < NREG; r++) begin
                mTv[i][r] = 0; mTag[i][r] = 0; mRdy[i][r] = 0;
            end
        mHead = 0; mTail = 0; mCount = 0;
    endtask

    task automatic expectSrc(input int k, input int idx, output int tv, output int tag, output int rdy);
        tv = 0; tag = 0; rdy = 0;
        if (idx != 0 && mTv[LIVE][idx] != 0) begin
            tv  = 1;
            tag = mTag[LIVE][idx];
            rdy = (mRdy[LIVE][idx] != 0 || cdbHit(tag)) ? 1 : 0;
        end
        for (int j = 0; j < k; j++)
            if (sDv[j] && idx != 0 && sDest[j] == idx) begin
                tv = 1; tag = sTag[j]; rdy = 0;
            end
    endtask

    task automatic checkModel();
        int tv, tag, rdy;
        for (int k = 0; k < DW; k++) begin
            expectSrc(k, sSrc1[k], tv, tag, rdy);
            checkOutput($sformatf("src1_tag_valid[%0d]", k), bus.src1_tag_valid[k], tv);
            checkOutput($sformatf("src1_tag[%0d]", k), bus.src1_tag[k*TW +: TW], tag);
            checkOutput($sformatf("src1_ready[%0d]", k), bus.src1_ready[k], rdy);
            expectSrc(k, sSrc2[k], tv, tag, rdy);
            checkOutput($sformatf("src2_tag_valid[%0d]", k), bus.src2_tag_valid[k], tv);
            checkOutput($sformatf("src2_tag[%0d]", k), bus.src2_tag[k*TW +: TW], tag);
            checkOutput($sformatf("src2_ready[%0d]", k), bus.src2_ready[k], rdy);
        end
        checkOutput("ckpt_id", bus.ckpt_id, mTail);
        checkOutput("ckpt_full", bus.ckpt_full, (mCount == NCK) ? 1 : 0);
        checkOutput("ckpt_empty", bus.ckpt_empty, (mCount == 0) ? 1 : 0);
    endtask

    task automatic modelStep();
        int aTv [NCK+1][NREG];
        int aTag[NCK+1][NREG];
        int aRdy[NCK+1][NREG];
        bit commitEff, take;
        for (int i = 0; i <= NCK; i++)
            for (int r = 0; r < NREG; r++) begin
                aTv[i][r] = mTv[i][r]; aTag[i][r] = mTag[i][r]; aRdy[i][r] = mRdy[i][r];
                if (aTv[i][r] != 0) begin
                    if (sRv && aTag[i][r] == sRtag) begin
                        aTv[i][r] = 0; aTag[i][r] = 0; aRdy[i][r] = 0;
                    end else if (cdbHit(aTag[i][r])) begin
                        aRdy[i][r] = 1;
                    end
                end
            end
        commitEff = sCommit && mCount > 0;
        take      = sReq && !sStall && mCount < NCK && !sRec;
        if (take) begin
            for (int r = 0; r < NREG; r++) begin
                aTv[mTail][r] = aTv[LIVE][r]; aTag[mTail][r] = aTag[LIVE][r]; aRdy[mTail][r] = aRdy[LIVE][r];
            end
            for (int k = 0; k <= sSlot; k++)
                if (sDv[k] && sDest[k] != 0) begin
                    aTv[mTail][sDest[k]] = 1; aTag[mTail][sDest[k]] = sTag[k]; aRdy[mTail][sDest[k]] = 0;
                end
        end
        if (sRec) begin
            for (int r = 0; r < NREG; r++) begin
                aTv[LIVE][r] = aTv[sRid][r]; aTag[LIVE][r] = aTag[sRid][r]; aRdy[LIVE][r] = aRdy[sRid][r];
            end
        end else if (!sStall) begin
            for (int k = 0; k < DW; k++)
                if (sDv[k] && sDest[k] != 0) begin
                    aTv[LIVE][sDest[k]] = 1; aTag[LIVE][sDest[k]] = sTag[k]; aRdy[LIVE][sDest[k]] = 0;
                end
        end
        mTv = aTv; mTag = aTag; mRdy = aRdy;
        if (commitEff) mHead = (mHead + 1) % NCK;
        if (sRec) begin
            mTail  = sRid;
            mCount = (sRid - mHead + NCK) % NCK;
        end else begin
            if (take) begin mTail = (mTail + 1) % NCK; mCount++; end
            if (commitEff) mCount--;
        end
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        driveInputs();
        #1;
        checkModel();
    endtask

    task automatic advance();
        modelStep();
        @(posedge clock);
    endtask

    task automatic cycle();
        applyStimulus();
        advance();
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        clearStim();
        driveInputs();
        @(posedge clock);
        @(posedge clock);
        modelReset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic randomStim();
        int cntAfter, headAfter;
        sStall = ($urandom_range(0, 7) == 0);
        sDv    = DW'($urandom);
        for (int k = 0; k < DW; k++) begin
            sDest[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7);
            sTag[k]  = $urandom_range(0, 11);
            sSrc1[k] = $urandom_range(0, 7);
            sSrc2[k] = $urandom_range(0, 7);
        end
        sCv = CW'($urandom);
        for (int c = 0; c < CW; c++) sCtag[c] = $urandom_range(0, 11);
        sRv     = ($urandom_range(0, 3) == 0);
        sRtag   = $urandom_range(0, 11);
        sReq    = ($urandom_range(0, 2) == 0);
        sSlot   = $urandom_range(0, DW-1);
        sCommit = ($urandom_range(0, 3) == 0);
        cntAfter  = mCount - ((sCommit && mCount > 0) ? 1 : 0);
        headAfter = (mHead + ((sCommit && mCount > 0) ? 1 : 0)) % NCK;
        sRec = ($urandom_range(0, 7) == 0) && cntAfter > 0;
        sRid = sRec ? (headAfter + $urandom_range(0, cntAfter - 1)) % NCK : 0;
    endtask

    initial begin
        reset = 1'b1;
        clearStim();
        modelReset();
        doReset();

        // Basic rename, then CDB wakeup seen combinationally and after the edge.
        clearStim(); sSrc1[0] = 5;
        applyStimulus();
        checkOutput("reset_tv5", bus.src1_tag_valid[0], 0);
        checkOutput("reset_empty", bus.ckpt_empty, 1);
        checkOutput("reset_full", bus.ckpt_full, 0);
        checkOutput("reset_id", bus.ckpt_id, 0);
        advance();
        clearStim(); sDv = 2'b01; sDest[0] = 5; sTag[0] = 3; cycle();
        clearStim(); sSrc1[0] = 5;
        applyStimulus();
        checkOutput("r5_tag", bus.src1_tag[TW-1:0], 3);
        checkOutput("r5_rdy0", bus.src1_ready[0], 0);
        advance();
        clearStim(); sSrc1[0] = 5; sCv = 2'b01; sCtag[0] = 3;
        applyStimulus();
        checkOutput("r5_cdb_bypass", bus.src1_ready[0], 1);
        advance();
        clearStim(); sSrc1[0] = 5;
        applyStimulus();
        checkOutput("r5_rdy_reg", bus.src1_ready[0], 1);
        advance();

        // Same-group bypass and youngest-writer-wins.
        clearStim(); sDv = 2'b11; sDest[0] = 7; sTag[0] = 1; sDest[1] = 7; sTag[1] = 2; sSrc2[1] = 7;
        applyStimulus();
        checkOutput("bypass_tag", bus.src2_tag[2*TW-1:TW], 1);
        checkOutput("bypass_rdy", bus.src2_ready[1], 0);
        advance();
        clearStim(); sSrc1[0] = 7;
        applyStimulus();
        checkOutput("r7_tag", bus.src1_tag[TW-1:0], 2);
        advance();

        // Mid-group checkpoint then recovery.
        clearStim(); sDv = 2'b01; sDest[0] = 4; sTag[0] = 9; cycle();
        clearStim(); sCv = 2'b10; sCtag[1] = 9; cycle();
        clearStim(); sDv = 2'b11; sDest[0] = 4; sTag[0] = 10; sDest[1] = 6; sTag[1] = 11;
        sReq = 1; sSlot = 0; cycle();
        clearStim(); sRec = 1; sRid = 0; cycle();
        clearStim(); sSrc1[0] = 4; sSrc2[0] = 6;
        applyStimulus();
        checkOutput("rec_r4_tag", bus.src1_tag[TW-1:0], 10);
        checkOutput("rec_r6_tv", bus.src2_tag_valid[0], 0);
        checkOutput("rec_empty", bus.ckpt_empty, 1);
        advance();

        // Snapshot freshness across a CDB broadcast.
        clearStim(); sReq = 1; cycle();
        clearStim(); sCv = 2'b01; sCtag[0] = 10; sDv = 2'b01; sDest[0] = 4; sTag[0] = 13; cycle();
        clearStim(); sRec = 1; sRid = 0; cycle();
        clearStim(); sSrc1[1] = 4;
        applyStimulus();
        checkOutput("fresh_tag", bus.src1_tag[2*TW-1:TW], 10);
        checkOutput("fresh_rdy", bus.src1_ready[1], 1);
        advance();

        // Fill, drop, commit and wrap of the checkpoint ring.
        clearStim(); sReq = 1; repeat (4) cycle();
        clearStim(); sReq = 1;
        applyStimulus();
        checkOutput("fill_full", bus.ckpt_full, 1);
        checkOutput("fill_id", bus.ckpt_id, 0);
        advance();
        clearStim(); sCommit = 1;
        applyStimulus();
        checkOutput("drop_id", bus.ckpt_id, 0);
        advance();
        clearStim(); sReq = 1;
        applyStimulus();
        checkOutput("commit_full", bus.ckpt_full, 0);
        advance();
        clearStim(); sReq = 1; sCommit = 1;
        applyStimulus();
        checkOutput("wrap_id", bus.ckpt_id, 1);
        advance();
        clearStim(); sCommit = 1; repeat (3) cycle();
        clearStim();
        applyStimulus();
        checkOutput("drain_empty", bus.ckpt_empty, 1);
        advance();

        // Retire/CDB/dispatch/stall conflicts on one register.
        clearStim(); sDv = 2'b01; sDest[0] = 4; sTag[0] = 10; cycle();
        clearStim(); sRv = 1; sRtag = 10; sCv = 2'b01; sCtag[0] = 10; cycle();
        clearStim(); sSrc1[0] = 4;
        applyStimulus();
        checkOutput("ret_cdb_tv", bus.src1_tag_valid[0], 0);
        advance();
        clearStim(); sDv = 2'b10; sDest[1] = 4; sTag[1] = 12; sRv = 1; sRtag = 12; cycle();
        clearStim(); sSrc1[0] = 4;
        applyStimulus();
        checkOutput("disp_over_ret", bus.src1_tag[TW-1:0], 12);
        advance();
        clearStim(); sStall = 1; sDv = 2'b01; sDest[0] = 4; sTag[0] = 14; sCv = 2'b01; sCtag[0] = 12; cycle();
        clearStim(); sSrc1[0] = 4;
        applyStimulus();
        checkOutput("stall_tag", bus.src1_tag[TW-1:0], 12);
        checkOutput("stall_rdy", bus.src1_ready[0], 1);
        advance();

        for (int n = 0; n < 600; n++) begin
            randomStim();
            cycle();
        end
        doReset();
        clearStim();
        applyStimulus();
        checkOutput("mid_reset_empty", bus.ckpt_empty, 1);
        advance();
        for (int n = 0; n < 200; n++) begin
            randomStim();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
